mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Memory-access/write-back stage directly downstream of the execute stage.
- Accepts one retired EX operation at a time over a valid/ready handshake.
- Performs the load or store against data memory using a variable-latency handshake with timeout and alignment checks.
- Writes ALU or load results into the register file and back-pressures EX while busy.

Parameters:
- TIMEOUT, 16: max cycles in ACCESS waiting for data_memory_ready before faulting (>=1).
- CHECK_ALIGN, 1: when 1, load/store addresses with addr[1:0]!=0 fault without a memory access.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- ex_valid  in  1  EX presents an operation
- ex_ready  out  1  stage can accept; high only in IDLE
- ex_is_load  in  1  operation is LOAD; result field is the address
- ex_is_store  in  1  operation is STORE; result field is the address
- ex_wen  in  1  operation writes a register (ALU/MOV/shift ops)
- ex_dest_reg  in  3  destination register index
- ex_result  in  32  ALU result or memory address
- ex_store_data  in  32  value to store
- data_memory_a  out  32  memory address
- data_memory_out_v  out  32  memory write data
- data_memory_read  out  1  read strobe
- data_memory_write  out  1  write strobe
- data_memory_in_v  in  32  memory read data, valid when ready is high
- data_memory_ready  in  1  memory completes the access this cycle
- w_enable  out  1  register-file write enable, one-cycle pulse
- w_addr  out  3  register-file write index
- w_data  out  32  register-file write data
- mem_fault  out  1  sticky; set on timeout or misalignment
- retired_count  out  32  operations completed (wraps)

Behaviour:
- Reset values: all outputs 0, except ex_ready=1 after reset deasserts. State is IDLE and the timeout counter is 0.
- States: IDLE, ACCESS, WB.
- IDLE, when ex_valid=1 (ex_ready=1): latch all ex_* fields.
  - Load (ex_is_load=1; wins if both load and store flags are set): go to ACCESS with data_memory_read=1.
  - Else store: go to ACCESS with data_memory_write=1.
  - Else ex_wen=1: go to WB.
  - Else: stay in IDLE and increment retired_count.
- Misalignment: if CHECK_ALIGN=1 and the load/store address[1:0]!=0, set mem_fault, issue no strobe, stay in IDLE, increment retired_count.
- ACCESS:
  - Strobe held high and address/data held stable each cycle until data_memory_ready=1.
  - On ready with load: capture in_v into w_data, drop strobe, go to WB.
  - On ready with store: drop strobe, go to IDLE, increment retired_count.
  - Counter increments each ACCESS cycle without ready. If the counter reaches TIMEOUT: drop strobe, set mem_fault, no register write, go to IDLE, increment retired_count.
  - Ready arriving in the same cycle the counter hits TIMEOUT counts as success.
- WB: w_enable=1 for exactly one cycle, with w_addr=dest and w_data=(load data or latched ex_result). Go to IDLE and increment retired_count.
- Latency:
  - ALU op accepted at edge N: w_enable high in cycle N+1.
  - Load with ready on the first ACCESS cycle: strobe in cycle N+1, w_enable in cycle N+2.
  - ex_ready low for the whole operation; the next accept happens no earlier than the edge after the WB/ACCESS exit.
- data_memory_read and data_memory_write are never high together. Strobes are registered outputs.
- retired_count wraps from 0xFFFFFFFF to 0.
- mem_fault clears only on rst.
- Reset mid-operation: immediate return to IDLE; strobes and w_enable drop asynchronously; the pending access is abandoned without write-back.

Test Plan:
- ALU op: ex_wen=1, dest=3, result=0x0000_1234 accepted at cycle 0 → w_enable=1, w_addr=3, w_data=0x1234 at cycle 1; ex_ready=0 at cycle 1; retired_count=1.
- Load, 2 wait states: addr=0x40, memory ready on 3rd ACCESS cycle with in_v=0xCAFEF00D → read strobe held 3 cycles at addr 0x40, then w_enable with w_data=0xCAFEF00D, dest as latched.
- Store: addr=0x80, data=0x55AA55AA, ready on the first cycle → one-cycle write strobe, out_v=0x55AA55AA, no w_enable, ex_ready high the next cycle.
- Timeout: TIMEOUT=4, load, ready never asserted → strobe high 4 cycles then low, mem_fault=1, no w_enable, back to IDLE.
- Misaligned store: addr=0x42 → no strobe, mem_fault=1, retired_count incremented.
- Reset asserted during ACCESS wait → strobe drops without waiting for clock, no w_enable, mem_fault=0, ex_ready=1 after release.

Source files
------------

// File: rtl/mem_wb_stage.sv
// Memory-access / write-back stage: takes one EX operation at a time, runs the
// load or store against a variable-latency data memory, then writes the register file.
module mem_wb_stage #(
    parameter int unsigned TIMEOUT     = 16,
    parameter bit          CHECK_ALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        ex_is_load,
    input  logic        ex_is_store,
    input  logic        ex_wen,
    input  logic [2:0]  ex_dest_reg,
    input  logic [31:0] ex_result,
    input  logic [31:0] ex_store_data,
    output logic [31:0] data_memory_a,
    output logic [31:0] data_memory_out_v,
    output logic        data_memory_read,
    output logic        data_memory_write,
    input  logic [31:0] data_memory_in_v,
    input  logic        data_memory_ready,
    output logic        w_enable,
    output logic [2:0]  w_addr,
    output logic [31:0] w_data,
    output logic        mem_fault,
    output logic [31:0] retired_count
);

    localparam int unsigned    CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, WB} state_t;

    state_t        state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   sdata_q, sdata_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   retired_q, retired_d;
    logic [2:0]    dest_q, dest_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;
    logic          fault_q, fault_d;
    logic          retire;
    logic          misaligned;

    assign misaligned = CHECK_ALIGN && (ex_result[1:0] != 2'b00);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        sdata_d   = sdata_q;
        wdata_d   = wdata_q;
        dest_d    = dest_q;
        cnt_d     = cnt_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        fault_d   = fault_q;
        retire    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    addr_d  = ex_result;
                    sdata_d = ex_store_data;
                    wdata_d = ex_result;
                    dest_d  = ex_dest_reg;
                    cnt_d   = '0;
                    if (ex_is_load || ex_is_store) begin
                        if (misaligned) begin
                            fault_d = 1'b1;
                            retire  = 1'b1;
                        end else begin
                            state_d = ACCESS;
                            rd_d    = ex_is_load;
                            wr_d    = !ex_is_load;
                        end
                    end else if (ex_wen) begin
                        state_d = WB;
                    end else begin
                        retire = 1'b1;
                    end
                end
            end
            ACCESS: begin
                // Ready takes priority over the timeout on the final allowed cycle
                if (data_memory_ready) begin
                    rd_d  = 1'b0;
                    wr_d  = 1'b0;
                    cnt_d = '0;
                    if (rd_q) begin
                        wdata_d = data_memory_in_v;
                        state_d = WB;
                    end else begin
                        state_d = IDLE;
                        retire  = 1'b1;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    cnt_d   = '0;
                    fault_d = 1'b1;
                    state_d = IDLE;
                    retire  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WB: begin
                state_d = IDLE;
                retire  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        retired_d = retire ? retired_q + 32'd1 : retired_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            sdata_q   <= '0;
            wdata_q   <= '0;
            dest_q    <= '0;
            cnt_q     <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            fault_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            sdata_q   <= sdata_d;
            wdata_q   <= wdata_d;
            dest_q    <= dest_d;
            cnt_q     <= cnt_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            fault_q   <= fault_d;
            retired_q <= retired_d;
        end
    end

    assign ex_ready          = (state_q == IDLE) && !rst;
    assign w_enable          = (state_q == WB);
    assign w_addr            = dest_q;
    assign w_data            = wdata_q;
    assign data_memory_a     = addr_q;
    assign data_memory_out_v = sdata_q;
    assign data_memory_read  = rd_q;
    assign data_memory_write = wr_q;
    assign mem_fault         = fault_q;
    assign retired_count     = retired_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: a driver predicts each operation's memory
// and register-file events, a monitor checks them as the DUT presents them.
module tb_mem_wb_stage;

    localparam int unsigned TMO   = 4;
    localparam int          NEVER = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_ready, ex_is_load, ex_is_store, ex_wen;
    logic [2:0]  ex_dest_reg;
    logic [31:0] ex_result, ex_store_data;
    logic [31:0] data_memory_a, data_memory_out_v, data_memory_in_v;
    logic        data_memory_read, data_memory_write, data_memory_ready;
    logic        w_enable;
    logic [2:0]  w_addr;
    logic [31:0] w_data;
    logic        mem_fault;
    logic [31:0] retired_count;

    mem_wb_stage #(.TIMEOUT(TMO), .CHECK_ALIGN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_is_load(ex_is_load), .ex_is_store(ex_is_store), .ex_wen(ex_wen),
        .ex_dest_reg(ex_dest_reg), .ex_result(ex_result), .ex_store_data(ex_store_data),
        .data_memory_a(data_memory_a), .data_memory_out_v(data_memory_out_v),
        .data_memory_read(data_memory_read), .data_memory_write(data_memory_write),
        .data_memory_in_v(data_memory_in_v), .data_memory_ready(data_memory_ready),
        .w_enable(w_enable), .w_addr(w_addr), .w_data(w_data),
        .mem_fault(mem_fault), .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    // kind: 0 = register write, 1 = memory read, 2 = memory write
    typedef struct {
        int          kind;
        logic [2:0]  dest;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    ev_t         sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          mem_lat = 0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] exp_ret   = '0;
    logic        exp_fault = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory responder: asserts ready after mem_lat wait cycles of a held strobe
    initial begin
        int cnt;
        cnt = 0;
        data_memory_ready = 1'b0;
        data_memory_in_v  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst || !(data_memory_read || data_memory_write)) begin
                cnt = 0;
                data_memory_ready = 1'b0;
                data_memory_in_v  = '0;
            end else begin
                if (cnt == mem_lat) begin
                    data_memory_ready = 1'b1;
                    data_memory_in_v  = mem_rdata;
                end else begin
                    data_memory_ready = 1'b0;
                    data_memory_in_v  = $urandom;
                end
                cnt++;
            end
        end
    end

    // Monitor: pops the scoreboard on each completed memory access or register write
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (data_memory_read && data_memory_write)
                    chk("strobe_exclusive", {30'd0, data_memory_read, data_memory_write}, 32'd0);
                if ((data_memory_read || data_memory_write) && data_memory_ready) begin
                    if (sb.size() == 0) chk("unexpected_mem_access", sb.size(), 32'd1);
                    else begin
                        e = sb.pop_front();
                        chk("mem_kind", data_memory_read ? 32'd1 : 32'd2, e.kind);
                        chk("mem_addr", data_memory_a, e.addr);
                        if (data_memory_write) chk("mem_wdata", data_memory_out_v, e.data);
                    end
                end
                if (w_enable) begin
                    if (sb.size() == 0) chk("unexpected_wb", sb.size(), 32'd1);
                    else begin
                        e = sb.pop_front();
                        chk("wb_kind", 32'd0, e.kind);
                        chk("wb_addr", {29'd0, w_addr}, {29'd0, e.dest});
                        chk("wb_data", w_data, e.data);
                    end
                end
            end
        end
    end

    // Issue one op from an idle stage; the reference model predicts events and cycle count
    task automatic issue(input logic ld, input logic st, input logic wen, input logic [2:0] dest,
                         input logic [31:0] res, input logic [31:0] sd, input int lat,
                         input logic [31:0] rdata);
        int  exp_cyc, cyc;
        bit  ok;
        ok = (lat < int'(TMO));
        if (ld || st) begin
            if (res[1:0] != 2'b00) begin
                exp_fault = 1'b1;
                exp_cyc   = 0;
            end else if (!ok) begin
                exp_fault = 1'b1;
                exp_cyc   = TMO;
            end else if (ld) begin
                sb.push_back('{1, 3'd0, res, 32'd0});
                sb.push_back('{0, dest, 32'd0, rdata});
                exp_cyc = lat + 2;
            end else begin
                sb.push_back('{2, 3'd0, res, sd});
                exp_cyc = lat + 1;
            end
        end else if (wen) begin
            sb.push_back('{0, dest, 32'd0, res});
            exp_cyc = 1;
        end else begin
            exp_cyc = 0;
        end
        exp_ret++;
        mem_lat       = lat;
        mem_rdata     = rdata;
        ex_is_load    = ld;
        ex_is_store   = st;
        ex_wen        = wen;
        ex_dest_reg   = dest;
        ex_result     = res;
        ex_store_data = sd;
        ex_valid      = 1'b1;
        @(posedge clk);
        #1;
        ex_valid      = 1'b0;
        ex_result     = $urandom;
        ex_store_data = $urandom;
        cyc = 0;
        while (!ex_ready && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("op_cycles", cyc, exp_cyc);
        chk("retired_count", retired_count, exp_ret);
        chk("mem_fault", {31'd0, mem_fault}, {31'd0, exp_fault});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t, ls;
        logic        ld, st, wen;
        logic [31:0] res;
        rst = 1'b1;
        ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0; ex_wen = 1'b0;
        ex_dest_reg = '0; ex_result = '0; ex_store_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_w_enable", {31'd0, w_enable}, 32'd0);
        chk("rst_strobes", {30'd0, data_memory_read, data_memory_write}, 32'd0);
        chk("rst_fault", {31'd0, mem_fault}, 32'd0);
        chk("rst_retired", retired_count, 32'd0);
        chk("rst_w_data", w_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_ex_ready", {31'd0, ex_ready}, 32'd1);

        issue(1'b0, 1'b0, 1'b1, 3'd3, 32'h0000_1234, 32'd0, 0, 32'd0);
        issue(1'b1, 1'b0, 1'b0, 3'd5, 32'h0000_0040, 32'd0, 2, 32'hCAFE_F00D);
        issue(1'b0, 1'b1, 1'b0, 3'd1, 32'h0000_0080, 32'h55AA_55AA, 0, 32'd0);
        issue(1'b0, 1'b0, 1'b0, 3'd2, 32'h0000_0007, 32'd0, 0, 32'd0);
        issue(1'b1, 1'b0, 1'b0, 3'd6, 32'h0000_0100, 32'd0, NEVER, 32'd0);
        issue(1'b0, 1'b1, 1'b0, 3'd0, 32'h0000_0042, 32'h1111_2222, 0, 32'd0);
        issue(1'b1, 1'b0, 1'b1, 3'd7, 32'h0000_0200, 32'd0, TMO - 1, 32'hDEAD_BEEF);
        issue(1'b1, 1'b1, 1'b1, 3'd4, 32'h0000_0300, 32'h9999_9999, 1, 32'h0BAD_CAFE);

        // Reset during an ACCESS wait: strobe must drop without a clock edge
        mem_lat = NEVER;
        ex_is_load = 1'b1; ex_is_store = 1'b0; ex_wen = 1'b1;
        ex_dest_reg = 3'd2; ex_result = 32'h0000_0400; ex_valid = 1'b1;
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_strobe_before", {31'd0, data_memory_read}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_strobe_async", {30'd0, data_memory_read, data_memory_write}, 32'd0);
        chk("mid_rst_w_enable", {31'd0, w_enable}, 32'd0);
        sb.delete();
        exp_ret   = '0;
        exp_fault = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_ex_ready", {31'd0, ex_ready}, 32'd1);
        chk("mid_rst_fault", {31'd0, mem_fault}, 32'd0);
        chk("mid_rst_retired", retired_count, 32'd0);
        chk("mid_rst_no_wb", {31'd0, w_enable}, 32'd0);

        for (int i = 0; i < 200; i++) begin
            t   = $urandom_range(0, 3);
            ld  = (t == 2);
            st  = (t == 3) || (t == 2 && $urandom_range(0, 3) == 0);
            wen = (t == 0) || ($urandom_range(0, 1) == 1 && t != 1);
            res = $urandom;
            if ((ld || st) && $urandom_range(0, 3) != 0) res[1:0] = 2'b00;
            ls = $urandom_range(0, 5);
            issue(ld, st, wen, 3'($urandom_range(0, 7)), res, $urandom,
                  (ls == 5) ? NEVER : ((ls == 4) ? int'(TMO) - 1 : ls), $urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
